invader_renderer: RTL
=====================

// Module: invader_renderer
// PURPOSE
//  Pixel-colour source feeding the VGA output stage: owns the 5x11 invader formation
//  (alive bitmap, position, march state) and returns an RRRGGGBB colour for each pixel
//  coordinate produced by the timing generator. Formation marches once per MOVE_DIV frames
//  and drops a row on each edge bounce. Player/shot logic clears invaders via the kill port.
// PARAMETERS
//  ROWS      5    formation rows
//  COLS      11   formation columns
//  CELL_W    24   horizontal pitch of one invader cell, px
//  CELL_H    16   vertical pitch of one invader cell, px
//  SPR_W     16   lit sprite width inside a cell (from cell left edge), px
//  SPR_H     8    lit sprite height inside a cell (from cell top edge), px
//  START_X   64   formation x at reset
//  START_Y   48   formation y at reset
//  STEP_X    8    horizontal march step, px
//  DROP_Y    8    vertical drop on edge bounce, px
//  MOVE_DIV  30   frames between march steps (>=1)
//  SCREEN_W  640  visible width;  BOTTOM_Y 400  landing line
// PORTS
//  clk            in   1   system clock
//  rst            in   1   synchronous active-high reset
//  pixel_en       in   1   pixel-rate enable; pipeline advances only when high
//  hpos           in   10  current pixel x (valid with pixel_en)
//  vpos           in   10  current pixel y (valid with pixel_en)
//  video_on       in   1   pixel is in visible area
//  frame_tick     in   1   one-clk pulse at end of visible frame (timing update strobe)
//  kill_valid     in   1   clear one invader this clk
//  kill_row       in   3   row of invader to clear
//  kill_col       in   4   column of invader to clear
//  color          out  8   RRRGGGBB pixel colour, 2 enabled pixels after inputs
//  formation_x    out  10  current formation left edge
//  formation_y    out  10  current formation top edge
//  alive_count    out  6   number of live invaders
//  all_dead       out  1   alive_count == 0
//  landed         out  1   formation_y + ROWS*CELL_H >= BOTTOM_Y (sticky until rst)
// BEHAVIOUR
//  One clock; reset is synchronous and active-high. Reset: all 55 alive, alive_count=55,
//   formation_x=START_X, formation_y=START_Y, direction=right, frame counter=0,
//   color=0, landed=0, pipeline valid bits cleared.
//  Render pipeline (both stages advance only on pixel_en; hold otherwise):
//   S1: dx=hpos-formation_x, dy=vpos-formation_y (11b signed); in_box when
//       0<=dx<COLS*CELL_W and 0<=dy<ROWS*CELL_H; col=dx/CELL_W, row=dy/CELL_H,
//       in_spr = (dx%CELL_W)<SPR_W && (dy%CELL_H)<SPR_H; register row,col,flags,video_on.
//   S2: lit = video_on & in_box & in_spr & alive[row][col] (alive sampled at S2).
//       color = lit ? row0:8'b111_000_11, rows1-2:8'b000_111_11, rows3-4:8'b000_111_00 : 8'h00.
//   Latency exactly 2 pixel_en cycles; video_on=0 always gives 8'h00.
//  March FSM states: MARCH (counting frames), FROZEN.
//   MARCH: on frame_tick, frame counter++; when it reaches MOVE_DIV-1, reset to 0 and step:
//    right: if formation_x+STEP_X+COLS*CELL_W-(CELL_W-SPR_W) > SCREEN_W -> y+=DROP_Y, dir=left;
//           else x+=STEP_X.
//    left : if formation_x < STEP_X -> y+=DROP_Y, dir=right; else x-=STEP_X.
//    Drop replaces the horizontal step (no x change that step).
//   MARCH->FROZEN when all_dead or landed; FROZEN holds position; only rst exits.
//   Position changes only on frame_tick (blanking), never mid-frame.
//  Kill: kill_valid with row<ROWS, col<COLS and bit alive -> clear bit, alive_count-1 on same
//   clk edge. Dead target or out-of-range index: no effect. Kill coincident with frame_tick:
//   both take effect. Kill during rst: ignored.
//  all_dead, landed combinational from registered state; landed set on the step that causes it.
//  Width: all position arithmetic 11b signed internally; no wrap beyond 0..SCREEN_W-1.
// TESTING
//  Reset, sweep frame: pixel (64,48) -> 8'b111_000_11 two enables later; (80,48) -> 0 (gap col);
//   (64,56) -> 0 (gap row); (64,112) -> 8'b000_111_00; video_on=0 anywhere -> 0.
//  pixel_en low for 5 clks mid-stream -> color holds, no sample skipped or duplicated.
//  kill row0 col0, then render (64,48) -> 0; alive_count 54; repeat same kill -> still 54.
//  30 frame_ticks -> formation_x=72; march right until bounce -> formation_y=56, dir left,
//   x unchanged at bounce step; then next step x-=8.
//  Kill all 55 (incl. one coincident with frame_tick) -> all_dead=1, position frozen afterwards.
//  Run marching to bottom -> landed=1 when y+80>=400, frozen; rst mid-march -> all reset values.

Source files
------------

// File: rtl/invader_renderer.sv
// Pixel-colour source for the VGA stage: owns the 5x11 invader formation (alive map,
// position, march state) and returns an RRRGGGBB colour per pixel through a 2-stage pipeline.
module invader_renderer #(
  parameter int ROWS     = 5,
  parameter int COLS     = 11,
  parameter int CELL_W   = 24,
  parameter int CELL_H   = 16,
  parameter int SPR_W    = 16,
  parameter int SPR_H    = 8,
  parameter int START_X  = 64,
  parameter int START_Y  = 48,
  parameter int STEP_X   = 8,
  parameter int DROP_Y   = 8,
  parameter int MOVE_DIV = 30,
  parameter int SCREEN_W = 640,
  parameter int BOTTOM_Y = 400
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pixel_en,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic       video_on,
  input  logic       frame_tick,
  input  logic       kill_valid,
  input  logic [2:0] kill_row,
  input  logic [3:0] kill_col,
  output logic [7:0] color,
  output logic [9:0] formation_x,
  output logic [9:0] formation_y,
  output logic [5:0] alive_count,
  output logic       all_dead,
  output logic       landed
);

  localparam int N     = ROWS * COLS;
  localparam int IDX_W = $clog2(N);
  localparam int CNT_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

  localparam logic signed [10:0] BOX_W_S = 11'(COLS * CELL_W);
  localparam logic signed [10:0] BOX_H_S = 11'(ROWS * CELL_H);
  localparam logic [9:0]  CELL_W10  = 10'(CELL_W);
  localparam logic [9:0]  CELL_H10  = 10'(CELL_H);
  localparam logic [9:0]  SPR_W10   = 10'(SPR_W);
  localparam logic [9:0]  SPR_H10   = 10'(SPR_H);
  localparam logic [9:0]  STEP10    = 10'(STEP_X);
  localparam logic [9:0]  DROP10    = 10'(DROP_Y);
  localparam logic [10:0] EDGE_ADD  = 11'(STEP_X + COLS * CELL_W - (CELL_W - SPR_W));
  localparam logic [10:0] SCREEN11  = 11'(SCREEN_W);
  localparam logic [10:0] BOX_H11   = 11'(ROWS * CELL_H);
  localparam logic [10:0] BOTTOM11  = 11'(BOTTOM_Y);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MOVE_DIV - 1);

  typedef enum logic {
    MARCH,
    FROZEN
  } march_state_t;

  march_state_t state, state_next;

  logic [N-1:0]     alive;
  logic [5:0]       alive_cnt;
  logic [9:0]       pos_x, pos_y, x_next, y_next;
  logic             dir_left, dir_next;
  logic [CNT_W-1:0] frame_cnt, cnt_next;

  // Stage 1 geometry: offset from formation origin, then cell and in-sprite position.
  logic signed [10:0] dx, dy;
  logic [9:0]         dx_u, dy_u, rem_x, rem_y;
  logic [3:0]         col_c;
  logic [2:0]         row_c;
  logic               in_box_c, in_spr_c;

  assign dx   = $signed({1'b0, hpos}) - $signed({1'b0, pos_x});
  assign dy   = $signed({1'b0, vpos}) - $signed({1'b0, pos_y});
  assign dx_u = dx[9:0];
  assign dy_u = dy[9:0];

  always_comb begin
    in_box_c = (dx >= 11'sd0) && (dx < BOX_W_S) && (dy >= 11'sd0) && (dy < BOX_H_S);
    col_c    = '0;
    row_c    = '0;
    rem_x    = '0;
    rem_y    = '0;
    if (in_box_c) begin
      col_c = 4'(dx_u / CELL_W10);
      row_c = 3'(dy_u / CELL_H10);
      rem_x = dx_u - 10'(col_c) * CELL_W10;
      rem_y = dy_u - 10'(row_c) * CELL_H10;
    end
    in_spr_c = (rem_x < SPR_W10) && (rem_y < SPR_H10);
  end

  logic [2:0] row_q;
  logic [3:0] col_q;
  logic       in_box_q, in_spr_q, von_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q    <= '0;
      col_q    <= '0;
      in_box_q <= 1'b0;
      in_spr_q <= 1'b0;
      von_q    <= 1'b0;
    end else if (pixel_en) begin
      row_q    <= row_c;
      col_q    <= col_c;
      in_box_q <= in_box_c;
      in_spr_q <= in_spr_c;
      von_q    <= video_on;
    end
  end

  // Stage 2: the alive map is looked up here so a kill shows on the very next pixel.
  logic [IDX_W-1:0] pix_idx;
  logic             lit;
  logic [7:0]       color_c;

  assign pix_idx = IDX_W'(row_q) * IDX_W'(COLS) + IDX_W'(col_q);
  assign lit     = von_q & in_box_q & in_spr_q & alive[pix_idx];

  always_comb begin
    color_c = 8'h00;
    if (lit) begin
      if (row_q == 3'd0)      color_c = 8'b111_000_11;
      else if (row_q <= 3'd2) color_c = 8'b000_111_11;
      else                    color_c = 8'b000_111_00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)           color <= 8'h00;
    else if (pixel_en) color <= color_c;
  end

  logic [IDX_W-1:0] kill_idx;
  logic             kill_ok, kill_hit;

  assign kill_idx = IDX_W'(kill_row) * IDX_W'(COLS) + IDX_W'(kill_col);
  assign kill_ok  = kill_valid && (kill_row < 3'(ROWS)) && (kill_col < 4'(COLS));
  assign kill_hit = kill_ok && alive[kill_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      alive     <= '1;
      alive_cnt <= 6'(N);
    end else if (kill_hit) begin
      alive[kill_idx] <= 1'b0;
      alive_cnt       <= alive_cnt - 6'd1;
    end
  end

  assign all_dead = (alive_cnt == 6'd0);
  assign landed   = ({1'b0, pos_y} + BOX_H11) >= BOTTOM11;

  // March: freezing takes priority over a coincident frame tick; a bounce drops instead of stepping.
  always_comb begin
    state_next = state;
    x_next     = pos_x;
    y_next     = pos_y;
    dir_next   = dir_left;
    cnt_next   = frame_cnt;
    case (state)
      MARCH: begin
        if (all_dead || landed) begin
          state_next = FROZEN;
        end else if (frame_tick) begin
          if (frame_cnt == CNT_LAST) begin
            cnt_next = '0;
            if (!dir_left) begin
              if (({1'b0, pos_x} + EDGE_ADD) > SCREEN11) begin
                y_next   = pos_y + DROP10;
                dir_next = 1'b1;
              end else begin
                x_next = pos_x + STEP10;
              end
            end else begin
              if (pos_x < STEP10) begin
                y_next   = pos_y + DROP10;
                dir_next = 1'b0;
              end else begin
                x_next = pos_x - STEP10;
              end
            end
          end else begin
            cnt_next = frame_cnt + CNT_W'(1);
          end
        end
      end
      FROZEN: state_next = FROZEN;
      default: state_next = MARCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= MARCH;
      pos_x     <= 10'(START_X);
      pos_y     <= 10'(START_Y);
      dir_left  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state     <= state_next;
      pos_x     <= x_next;
      pos_y     <= y_next;
      dir_left  <= dir_next;
      frame_cnt <= cnt_next;
    end
  end

  assign formation_x = pos_x;
  assign formation_y = pos_y;
  assign alive_count = alive_cnt;

endmodule
